// File: rtl/operate_execute_unit.sv
// -----------------------------------------------------------------------------
// operate_execute_unit
//
// Executes one PDP-8 Operate (opcode 7) instruction per accepted start.
// The instruction, AC and L are captured and presented to an external
// combinational micro-instruction decoder. One cycle later the decoder
// results are sampled. The Group 2 post-skip actions (CLA, OSR, HLT) are then
// applied, and the next AC, L and PC are registered for the main sequencer.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle request; taken only in IDLE when not halted
//   instr, pc_in, ac_in,  instruction word, its PC, current AC / link,
//   l_in, switch_reg      front-panel switch register
//   clear_halt            clears the sticky halt flag
//   dec_i_reg/ac/l        registered instr[8:0], AC and link to the decoder
//   ac_micro, l_micro,    decoder results
//   skip, micro_g1..g3
//   ac_out, l_out, pc_out results, valid with done and held until the next done
//   busy                  high outside IDLE
//   done                  one-cycle completion pulse
//   halt                  sticky, set by HLT
//   illegal, unsupported  pulse with done for a non-operate opcode / Group 3
// -----------------------------------------------------------------------------
module operate_execute_unit #(
  parameter int WORD_W   = 12,
  parameter int DEC_IR_W = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WORD_W-1:0]   instr,
  input  logic [WORD_W-1:0]   pc_in,
  input  logic [WORD_W-1:0]   ac_in,
  input  logic                l_in,
  input  logic [WORD_W-1:0]   switch_reg,
  input  logic                clear_halt,
  output logic [DEC_IR_W-1:0] dec_i_reg,
  output logic [WORD_W-1:0]   dec_ac_reg,
  output logic                dec_l_reg,
  input  logic [WORD_W-1:0]   ac_micro,
  input  logic                l_micro,
  input  logic                skip,
  input  logic                micro_g1,
  input  logic                micro_g2,
  input  logic                micro_g3,
  output logic [WORD_W-1:0]   ac_out,
  output logic                l_out,
  output logic [WORD_W-1:0]   pc_out,
  output logic                busy,
  output logic                done,
  output logic                halt,
  output logic                illegal,
  output logic                unsupported
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_APPLY  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;

  logic [WORD_W-1:0]   ir_q, pc_q, ac_q, sw_q;
  logic                l_q;
  logic [WORD_W-1:0]   ac_out_q, pc_out_q;
  logic                l_out_q;
  logic                busy_q, done_q, halt_q, illegal_q, unsupported_q;
  logic                hlt_pend_q;

  logic                accept_s;
  logic                halt_d;
  logic [WORD_W-1:0]   res_ac_s, res_pc_s, g2_ac_s, pc_inc1_s, pc_inc2_s;
  logic                res_l_s, res_ill_s, res_uns_s, res_hlt_s;

  // A clear_halt arriving with start is honoured first, so start is taken.
  assign accept_s = (state_q == S_IDLE) && start && (!halt_q || clear_halt);

  // Next-state logic for the fixed four-step sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_DECODE;
        else          state_d = S_IDLE;
      end
      S_DECODE: state_d = S_APPLY;
      S_APPLY:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Result computation; only meaningful while in APPLY.
  always_comb begin
    pc_inc1_s = pc_q + {{(WORD_W-2){1'b0}}, 2'd1};
    pc_inc2_s = pc_q + {{(WORD_W-2){1'b0}}, 2'd2};
    res_ac_s  = ac_q;
    res_l_s   = l_q;
    res_pc_s  = pc_inc1_s;
    res_ill_s = 1'b0;
    res_uns_s = 1'b0;
    res_hlt_s = 1'b0;
    g2_ac_s   = ac_q;
    if (ir_q[WORD_W-1:WORD_W-3] != 3'b111) begin
      res_ill_s = 1'b1;
    end else if (micro_g1) begin
      res_ac_s = ac_micro;
      res_l_s  = l_micro;
    end else if (micro_g2) begin
      // Skip was evaluated by the decoder on the pre-CLA AC.
      if (skip) res_pc_s = pc_inc2_s;
      else      res_pc_s = pc_inc1_s;
      if (ir_q[7]) g2_ac_s = {WORD_W{1'b0}};
      else         g2_ac_s = ac_q;
      if (ir_q[2]) res_ac_s = g2_ac_s | sw_q;
      else         res_ac_s = g2_ac_s;
      res_hlt_s = ir_q[1];
    end else begin
      // Group 3, or no group flag at all: executed as a NOP.
      res_uns_s = 1'b1;
    end
  end

  // Sticky halt: setting by HLT wins over a simultaneous clear.
  always_comb begin
    halt_d = halt_q;
    if ((state_q == S_DONE) && hlt_pend_q) halt_d = 1'b1;
    else if (clear_halt)                    halt_d = 1'b0;
    else                                    halt_d = halt_q;
  end

  // State, operand capture, result and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ir_q          <= {WORD_W{1'b0}};
      pc_q          <= {WORD_W{1'b0}};
      ac_q          <= {WORD_W{1'b0}};
      sw_q          <= {WORD_W{1'b0}};
      l_q           <= 1'b0;
      ac_out_q      <= {WORD_W{1'b0}};
      pc_out_q      <= {WORD_W{1'b0}};
      l_out_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      halt_q        <= 1'b0;
      illegal_q     <= 1'b0;
      unsupported_q <= 1'b0;
      hlt_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_q == S_APPLY);
      illegal_q     <= (state_q == S_APPLY) && res_ill_s;
      unsupported_q <= (state_q == S_APPLY) && res_uns_s;
      halt_q        <= halt_d;
      if (accept_s) begin
        ir_q <= instr;
        pc_q <= pc_in;
        ac_q <= ac_in;
        l_q  <= l_in;
        sw_q <= switch_reg;
      end
      if (state_q == S_APPLY) begin
        ac_out_q   <= res_ac_s;
        l_out_q    <= res_l_s;
        pc_out_q   <= res_pc_s;
        hlt_pend_q <= res_hlt_s;
      end else if (state_q == S_DONE) begin
        hlt_pend_q <= 1'b0;
      end
    end
  end

  assign dec_i_reg   = ir_q[DEC_IR_W-1:0];
  assign dec_ac_reg  = ac_q;
  assign dec_l_reg   = l_q;
  assign ac_out      = ac_out_q;
  assign l_out       = l_out_q;
  assign pc_out      = pc_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halt        = halt_q;
  assign illegal     = illegal_q;
  assign unsupported = unsupported_q;

endmodule

// File: tb/tb_operate_execute_unit.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for operate_execute_unit. The external decoder
// is stood in for by per-vector, hand-derived decoder outputs.
// -----------------------------------------------------------------------------
module tb_operate_execute_unit;

  logic        clk = 1'b0;
  logic        reset, start, l_in, clear_halt;
  logic [11:0] instr, pc_in, ac_in, switch_reg;
  logic [8:0]  dec_i_reg;
  logic [11:0] dec_ac_reg;
  logic        dec_l_reg;
  logic [11:0] ac_micro;
  logic        l_micro, skip, micro_g1, micro_g2, micro_g3;
  logic [11:0] ac_out, pc_out;
  logic        l_out, busy, done, halt, illegal, unsupported;

  int n_checks = 0;
  int n_fail   = 0;

  operate_execute_unit #(.WORD_W(12), .DEC_IR_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .pc_in(pc_in),
    .ac_in(ac_in), .l_in(l_in), .switch_reg(switch_reg), .clear_halt(clear_halt),
    .dec_i_reg(dec_i_reg), .dec_ac_reg(dec_ac_reg), .dec_l_reg(dec_l_reg),
    .ac_micro(ac_micro), .l_micro(l_micro), .skip(skip),
    .micro_g1(micro_g1), .micro_g2(micro_g2), .micro_g3(micro_g3),
    .ac_out(ac_out), .l_out(l_out), .pc_out(pc_out), .busy(busy), .done(done),
    .halt(halt), .illegal(illegal), .unsupported(unsupported)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o, expected %0o", tag, obs, exp);
    end
  endtask

  // Issue one instruction at a negedge and check the whole 4-cycle sequence.
  task automatic run_op(input string name,
                        input logic [11:0] i_w, input logic [11:0] pc,
                        input logic [11:0] ac, input logic l, input logic [11:0] sw,
                        input logic [11:0] acm, input logic lm, input logic sk,
                        input logic g1, input logic g2, input logic g3, input logic clr,
                        input logic [11:0] exp_ac, input logic exp_l,
                        input logic [11:0] exp_pc, input logic exp_ill, input logic exp_uns);
    @(negedge clk);
    instr = i_w; pc_in = pc; ac_in = ac; l_in = l; switch_reg = sw;
    ac_micro = acm; l_micro = lm; skip = sk;
    micro_g1 = g1; micro_g2 = g2; micro_g3 = g3;
    start = 1'b1; clear_halt = clr;
    @(negedge clk);                              // N+1: DECODE
    start = 1'b0; clear_halt = 1'b0;
    check_eq({name, ".busy1"}, busy, 1'b1);
    check_eq({name, ".dec_i"}, dec_i_reg, i_w[8:0]);
    check_eq({name, ".dec_ac"}, dec_ac_reg, ac);
    check_eq({name, ".dec_l"}, dec_l_reg, l);
    @(negedge clk);                              // N+2: APPLY
    check_eq({name, ".done2"}, done, 1'b0);
    @(negedge clk);                              // N+3: DONE
    check_eq({name, ".done3"}, done, 1'b1);
    check_eq({name, ".busy3"}, busy, 1'b1);
    check_eq({name, ".ac"}, ac_out, exp_ac);
    check_eq({name, ".l"}, l_out, exp_l);
    check_eq({name, ".pc"}, pc_out, exp_pc);
    check_eq({name, ".ill"}, illegal, exp_ill);
    check_eq({name, ".uns"}, unsupported, exp_uns);
    @(negedge clk);                              // back in IDLE
    check_eq({name, ".busy4"}, busy, 1'b0);
    check_eq({name, ".done4"}, done, 1'b0);
    check_eq({name, ".ill4"}, illegal, 1'b0);
    check_eq({name, ".hold_pc"}, pc_out, exp_pc);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; start = 1'b0; clear_halt = 1'b0;
    instr = 12'o0; pc_in = 12'o0; ac_in = 12'o0; l_in = 1'b0; switch_reg = 12'o0;
    ac_micro = 12'o0; l_micro = 1'b0; skip = 1'b0;
    micro_g1 = 1'b0; micro_g2 = 1'b0; micro_g3 = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.done", done, 1'b0);
    check_eq("rst.halt", halt, 1'b0);
    check_eq("rst.ac", ac_out, 12'o0);
    check_eq("rst.pc", pc_out, 12'o0);
    check_eq("rst.dec_i", dec_i_reg, 9'o0);
    reset = 1'b0;

    //     name     instr    pc       ac       l     sw       ac_micro l_m   skip  g1    g2    g3    clr   exp_ac   exp_l exp_pc   ill   uns
    run_op("cla",   12'o7200, 12'o0100, 12'o1234, 1'b1, 12'o0,    12'o0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b1, 12'o0101, 1'b0, 1'b0);
    run_op("spa_p", 12'o7510, 12'o0100, 12'o0377, 1'b0, 12'o0,    12'o0377, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0377, 1'b0, 12'o0102, 1'b0, 1'b0);
    run_op("spa_n", 12'o7510, 12'o0100, 12'o4000, 1'b1, 12'o0,    12'o4000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o4000, 1'b1, 12'o0101, 1'b0, 1'b0);
    run_op("sza0",  12'o7640, 12'o0200, 12'o0000, 1'b0, 12'o0,    12'o0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0202, 1'b0, 1'b0);
    run_op("sza5",  12'o7640, 12'o0200, 12'o0005, 1'b0, 12'o0,    12'o0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0201, 1'b0, 1'b0);
    run_op("osr",   12'o7404, 12'o0300, 12'o0101, 1'b0, 12'o5252, 12'o0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o5353, 1'b0, 12'o0301, 1'b0, 1'b0);
    run_op("skp",   12'o7410, 12'o7777, 12'o0042, 1'b1, 12'o0,    12'o0042, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0042, 1'b1, 12'o0001, 1'b0, 1'b0);
    run_op("skpw",  12'o7410, 12'o7776, 12'o0042, 1'b0, 12'o0,    12'o0042, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0042, 1'b0, 12'o0000, 1'b0, 1'b0);
    run_op("ill",   12'o1234, 12'o0400, 12'o0777, 1'b1, 12'o0,    12'o1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'o0777, 1'b1, 12'o0401, 1'b1, 1'b0);
    run_op("g3",    12'o7421, 12'o0500, 12'o0123, 1'b1, 12'o0,    12'o7777, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'o0123, 1'b1, 12'o0501, 1'b0, 1'b1);
    run_op("nogrp", 12'o7000, 12'o0510, 12'o0321, 1'b0, 12'o0,    12'o7777, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'o0321, 1'b0, 12'o0511, 1'b0, 1'b1);
    run_op("g1_ml", 12'o7001, 12'o0520, 12'o7777, 1'b0, 12'o0,    12'o0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b1, 12'o0521, 1'b0, 1'b0);

    // HLT: halt appears after done, and blocks further starts.
    run_op("hlt",   12'o7402, 12'o0600, 12'o0017, 1'b0, 12'o0,    12'o0017, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0017, 1'b0, 12'o0601, 1'b0, 1'b0);
    check_eq("hlt.halt", halt, 1'b1);
    start = 1'b1; instr = 12'o7200;
    @(negedge clk);
    start = 1'b0;
    check_eq("hlt.ign_busy", busy, 1'b0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    check_eq("hlt.ign_done", seen, 1'b0);
    check_eq("hlt.still", halt, 1'b1);
    clear_halt = 1'b1;
    @(negedge clk);
    clear_halt = 1'b0;
    check_eq("hlt.clear", halt, 1'b0);
    run_op("after", 12'o7200, 12'o0700, 12'o0055, 1'b0, 12'o0,    12'o0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b0, 12'o0701, 1'b0, 1'b0);

    // Halt again, then clear_halt together with start: start is accepted.
    run_op("hlt2",  12'o7402, 12'o1000, 12'o0001, 1'b1, 12'o0,    12'o0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'o0001, 1'b1, 12'o1001, 1'b0, 1'b0);
    check_eq("hlt2.halt", halt, 1'b1);
    run_op("clrst", 12'o7410, 12'o1010, 12'o0002, 1'b0, 12'o0,    12'o0002, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'o0002, 1'b0, 12'o1012, 1'b0, 1'b0);
    check_eq("clrst.halt", halt, 1'b0);

    // Reset during DECODE: no done, everything cleared, FSM back to IDLE.
    @(negedge clk);
    instr = 12'o7200; pc_in = 12'o0100; ac_in = 12'o1234; l_in = 1'b1;
    micro_g1 = 1'b1; micro_g2 = 1'b0; micro_g3 = 1'b0; ac_micro = 12'o0; l_micro = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("mid.busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid.busy0", busy, 1'b0);
    check_eq("mid.ac", ac_out, 12'o0);
    check_eq("mid.pc", pc_out, 12'o0);
    check_eq("mid.l", l_out, 1'b0);
    check_eq("mid.dec_ac", dec_ac_reg, 12'o0);
    check_eq("mid.dec_i", dec_i_reg, 9'o0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    check_eq("mid.nodone", seen, 1'b0);
    run_op("post",  12'o7200, 12'o0100, 12'o1234, 1'b1, 12'o0,    12'o0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b1, 12'o0101, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operate_execute_unit.md
Name: operate_execute_unit

Overview:
- Sequential wrapper that executes one PDP-8 Operate (opcode 7) instruction per start request.
- Registers the instruction, AC and L, and drives them into the combinational micro-instruction decoder.
- Samples the decoder results, then applies the Group 2 post-skip actions (CLA, OSR, HLT).
- Produces the next AC, L and PC for the CPU's main sequencer.

Parameters:
- WORD_W, 12, width of AC, PC, switch register and instruction.
- DEC_IR_W, 9, width of instruction field driven to the decoder (instr[8:0]).

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; accepted only in IDLE with halt=0.
- instr  input  12  full instruction word.
- pc_in  input  12  PC of the instruction.
- ac_in  input  12  current AC.
- l_in  input  1  current link.
- switch_reg  input  12  front-panel switch register.
- clear_halt  input  1  clears sticky halt.
- dec_i_reg  output  9  to decoder: instr[8:0] (registered).
- dec_ac_reg  output  12  to decoder: AC (registered).
- dec_l_reg  output  1  to decoder: link (registered).
- ac_micro  input  12  from decoder.
- l_micro  input  1  from decoder.
- skip  input  1  from decoder.
- micro_g1, micro_g2, micro_g3  input  1 each  decoder group flags.
- ac_out  output  12  resulting AC.
- l_out  output  1  resulting link.
- pc_out  output  12  next PC.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse; outputs valid in this cycle.
- halt  output  1  sticky; set by HLT.
- illegal  output  1  pulses with done on non-operate opcode.
- unsupported  output  1  pulses with done on a Group 3 instruction.

Behaviour:
- Reset (synchronous, active-high):
  - State returns to IDLE.
  - All outputs clear to 0, including the dec_* registers, ac_out, pc_out and halt.
  - Reset wins over every other input, including mid-operation; the interrupted instruction produces no done.
- FSM: IDLE -> DECODE -> APPLY -> DONE -> IDLE.
  - IDLE: on start && !halt, latch instr, pc_in, ac_in, l_in and switch_reg. dec_i_reg=instr[8:0], dec_ac_reg=ac_in, dec_l_reg=l_in. Go to DECODE.
  - start while busy or halt=1 is ignored; it is not queued.
  - DECODE: the decoder settles on the registered inputs; nothing is sampled.
  - APPLY: sample ac_micro, l_micro, skip and the group flags; compute the results below and register them.
  - DONE: done=1 for one cycle; ac_out, l_out and pc_out hold until the next done or reset.
- Latency: start sampled in cycle N -> done high in cycle N+3. Maximum throughput is one instruction per 4 cycles.
- Opcode check: if instr[11:9] != 3'b111, then illegal=1 with done, ac_out=ac_in, l_out=l_in, pc_out=pc_in+1. No other effect.
- Group 1 (micro_g1): ac_out=ac_micro, l_out=l_micro, pc_out=pc+1.
- Group 2 (micro_g2):
  - The skip test uses the pre-CLA AC, as the decoder evaluates.
  - pc_out = pc+2 if skip, else pc+1.
  - Then, in order: if instr[7] (CLA), ac=0. If instr[2] (OSR), ac = ac | switch_reg.
  - If instr[1] (HLT), set halt.
  - l_out=l_in.
- Group 3 (micro_g3): treated as NOP. ac_out=ac_in, l_out=l_in, pc_out=pc+1, unsupported=1 with done.
- PC arithmetic is modulo 4096: 7777+1=0000, 7776+2=0000, 7777+2=0001.
- halt:
  - Sets in the DONE cycle of an HLT instruction.
  - Clears on clear_halt in any state; clearing is ignored in the same cycle that HLT sets it.
  - If clear_halt and start arrive in the same IDLE cycle, clear_halt takes effect first and start is accepted.
- Exactly one of micro_g1/micro_g2/micro_g3 is expected in APPLY. If none is set, the block behaves as Group 3.

Test Plan:
- instr=7200 (CLA), ac_in=1234, l_in=1, pc_in=0100, start at N -> done at N+3, ac_out=0000, l_out=1, pc_out=0101, busy high N+1..N+3.
- instr=7510 (SPA), ac_in=0377 -> pc_out=0102. Same with ac_in=4000 -> pc_out=0101. ac_out unchanged in both cases.
- instr=7640 (SZA CLA):
  - ac_in=0000, pc_in=0200 -> pc_out=0202, ac_out=0000.
  - ac_in=0005 -> pc_out=0201, ac_out=0000.
- instr=7404 (OSR), ac_in=0101, switch_reg=5252 -> ac_out=5353.
- instr=7402 (HLT) -> halt=1 after done. A following start produces no busy/done. After clear_halt, start is accepted.
- instr=7410 (SKP), pc_in=7777 -> pc_out=0001.
- instr=1234 -> illegal=1, pc_out=pc_in+1.
- Reset asserted during DECODE -> no done, all outputs 0, FSM back in IDLE.
